// File: rtl/tx_stream_if.sv
`default_nettype none
// ============================================================================
// tx_stream_if : 16-bit valid/ready word stream toward the radio/MAC
// Revision 1.0
// ============================================================================
interface tx_stream_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/tx_pkt_builder.sv
`default_nettype none
// ============================================================================
// tx_pkt_builder : EER-RL transmit packet assembler with two's-complement checksum
// Revision 1.0
// ============================================================================
module tx_pkt_builder #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        tx_req_i,
  input  logic [2:0]  tx_type_i,
  input  logic [15:0] my_node_id_i,
  input  logic [15:0] hops_from_sink_i,
  input  logic [15:0] my_q_value_i,
  input  logic [15:0] energy_i,
  input  logic [15:0] ch_id_i,
  input  logic [15:0] e_max_i,
  input  logic [15:0] e_min_i,
  input  logic [15:0] member_id_i,
  input  logic [15:0] timeslot_i,
  input  logic [15:0] data_in_i,
  tx_stream_if.master tx_o,
  output logic        tx_busy_o,
  output logic        tx_done_o,
  output logic        tx_err_o
);

  localparam logic [2:0]  C_TYPE_HB     = 3'd0;
  localparam logic [2:0]  C_TYPE_CH_ANN = 3'd1;
  localparam logic [2:0]  C_TYPE_JOIN   = 3'd2;
  localparam logic [2:0]  C_TYPE_DATA   = 3'd3;
  localparam logic [2:0]  C_TYPE_TSLOT  = 3'd4;
  localparam logic [15:0] C_STALL_MAX   = 16'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_CSUM = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  type_q;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] stall_q, stall_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;

  logic [15:0] id_q, hops_q, qv_q, energy_q, ch_id_q;
  logic [15:0] e_max_q, e_min_q, member_q, tslot_q, data_q;

  logic [15:0] hops_tx;
  logic [15:0] body_word;
  logic [15:0] header_word;
  logic [15:0] cur_word;
  logic [7:0]  word_count;
  logic [2:0]  last_idx;
  logic        handshake;

  // Body word selection; index 0 is the header, 1..word_count-2 are body words.
  always_comb begin
    hops_tx    = (hops_q == 16'hFFFF) ? 16'hFFFF : hops_q + 16'd1;
    body_word  = id_q;
    word_count = 8'd6;
    case (type_q)
      C_TYPE_HB: begin
        case (idx_q)
          3'd2:    body_word = hops_tx;
          3'd3:    body_word = qv_q;
          3'd4:    body_word = energy_q;
          default: body_word = id_q;
        endcase
      end
      C_TYPE_CH_ANN: begin
        case (idx_q)
          3'd2:    body_word = ch_id_q;
          3'd3:    body_word = e_max_q;
          3'd4:    body_word = e_min_q;
          default: body_word = id_q;
        endcase
      end
      C_TYPE_JOIN: begin
        word_count = 8'd5;
        case (idx_q)
          3'd2:    body_word = ch_id_q;
          3'd3:    body_word = qv_q;
          default: body_word = id_q;
        endcase
      end
      C_TYPE_DATA: begin
        case (idx_q)
          3'd2:    body_word = ch_id_q;
          3'd3:    body_word = hops_q;
          3'd4:    body_word = data_q;
          default: body_word = id_q;
        endcase
      end
      C_TYPE_TSLOT: begin
        word_count = 8'd5;
        case (idx_q)
          3'd2:    body_word = member_q;
          3'd3:    body_word = tslot_q;
          default: body_word = id_q;
        endcase
      end
      default: body_word = id_q;
    endcase
    header_word = {type_q, 5'b00000, word_count};
    last_idx    = word_count[2:0] - 3'd2;

    cur_word = 16'd0;
    if (state_q == S_SEND) begin
      cur_word = (idx_q == 3'd0) ? header_word : body_word;
    end else if (state_q == S_CSUM) begin
      cur_word = 16'd0 - sum_q;
    end
  end

  assign tx_o.out_data  = cur_word;
  assign tx_o.out_valid = (state_q != S_IDLE);
  assign tx_o.out_last  = (state_q == S_CSUM);
  assign handshake      = (state_q != S_IDLE) && tx_o.out_ready;
  assign tx_busy_o      = (state_q != S_IDLE);
  assign tx_done_o      = done_q;
  assign tx_err_o       = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_req_i) begin
          if (tx_type_i <= C_TYPE_TSLOT) begin
            accept  = 1'b1;
            state_d = S_SEND;
            idx_d   = 3'd0;
            sum_d   = 16'd0;
            stall_d = 16'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEND, S_CSUM: begin
        if (handshake) begin
          stall_d = 16'd0;
          sum_d   = sum_q + cur_word;
          if (state_q == S_CSUM) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            if (idx_q == last_idx) begin
              state_d = S_CSUM;
            end
          end
        end else if (stall_q == C_STALL_MAX) begin
          // This stalled cycle is the STALL_LIMIT-th in a row: abandon the packet.
          state_d = S_IDLE;
          stall_d = 16'd0;
          err_d   = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      sum_q   <= 16'd0;
      stall_q <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      type_q   <= 3'd0;
      id_q     <= 16'd0;
      hops_q   <= 16'd0;
      qv_q     <= 16'd0;
      energy_q <= 16'd0;
      ch_id_q  <= 16'd0;
      e_max_q  <= 16'd0;
      e_min_q  <= 16'd0;
      member_q <= 16'd0;
      tslot_q  <= 16'd0;
      data_q   <= 16'd0;
    end else if (accept) begin
      type_q   <= tx_type_i;
      id_q     <= my_node_id_i;
      hops_q   <= hops_from_sink_i;
      qv_q     <= my_q_value_i;
      energy_q <= energy_i;
      ch_id_q  <= ch_id_i;
      e_max_q  <= e_max_i;
      e_min_q  <= e_min_i;
      member_q <= member_id_i;
      tslot_q  <= timeslot_i;
      data_q   <= data_in_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_pkt_builder.sv
`default_nettype none
// ============================================================================
// tb_tx_pkt_builder : scoreboard bench for tx_pkt_builder
// Revision 1.0
// ============================================================================
module tb_tx_pkt_builder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        tx_req = 1'b0;
  logic [2:0]  tx_type = 3'd0;
  logic [15:0] id = '0, hops = '0, qv = '0, en = '0, chid = '0;
  logic [15:0] emax = '0, emin = '0, mem = '0, ts = '0, din = '0;
  logic        busy, done, err;

  tx_stream_if sif ();

  tx_pkt_builder #(.STALL_LIMIT(4)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .tx_req_i         (tx_req),
    .tx_type_i        (tx_type),
    .my_node_id_i     (id),
    .hops_from_sink_i (hops),
    .my_q_value_i     (qv),
    .energy_i         (en),
    .ch_id_i          (chid),
    .e_max_i          (emax),
    .e_min_i          (emin),
    .member_id_i      (mem),
    .timeslot_i       (ts),
    .data_in_i        (din),
    .tx_o             (sif),
    .tx_busy_o        (busy),
    .tx_done_o        (done),
    .tx_err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Push the first n words of a packet; the n-th is flagged last when is_full.
  task automatic exp_words(input int n, input bit is_full,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d, input logic [15:0] e, input logic [15:0] f);
    logic [15:0] w [6];
    w = '{a, b, c, d, e, f};
    for (int i = 0; i < n; i++) begin
      word_t x;
      x.data = w[i];
      x.last = is_full && (i == n - 1);
      exp_q.push_back(x);
    end
  endtask

  // Sink readiness: forced level, or random with at most two consecutive stalls.
  logic ready_force = 1'b1;
  bit   bp_en = 1'b0;
  int   lows = 0;
  always @(posedge clk) begin
    #2;
    if (bp_en) begin
      if (lows >= 2 || $urandom_range(0, 1) == 1) begin
        sif.out_ready = 1'b1;
        lows = 0;
      end else begin
        sif.out_ready = 1'b0;
        lows++;
      end
    end else begin
      sif.out_ready = ready_force;
      lows = 0;
    end
  end

  // Monitor: compare every accepted word with the scoreboard, and check hold stability.
  logic        stalled_prev = 1'b0;
  logic [15:0] held_data = '0;
  logic        held_last = 1'b0;
  always @(negedge clk) begin
    if (nrst && sif.out_valid) begin
      if (stalled_prev) begin
        check16("hold_data", sif.out_data, held_data);
        check1("hold_last", sif.out_last, held_last);
      end
      if (sif.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%04h expected none", sif.out_data);
        end else begin
          word_t x;
          x = exp_q.pop_front();
          check16("word", sif.out_data, x.data);
          check1("last", sif.out_last, x.last);
        end
        stalled_prev = 1'b0;
      end else begin
        stalled_prev = 1'b1;
        held_data    = sif.out_data;
        held_last    = sif.out_last;
      end
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic start(input logic [2:0] t);
    tx_type = t;
    tx_req  = 1'b1;
    @(posedge clk);
    #1;
    tx_req = 1'b0;
  endtask

  // Called in the first cycle after accept; cyc=1 means that cycle. cyc=0 on timeout.
  task automatic wait_end(input int pulse_at, output int cyc, output logic got_done, output logic got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    cyc      = 0;
    for (int c = 1; c <= 200; c++) begin
      tx_req = (c == pulse_at);
      if (c == pulse_at) tx_type = 3'd4;
      if (done || err) begin
        cyc      = c;
        got_done = done;
        got_err  = err;
        tx_req   = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tx_req = 1'b0;
  endtask

  int   cyc;
  logic gd, ge;

  initial begin
    sif.out_ready = 1'b1;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid", sif.out_valid, 1'b0);
    check1("rst_last", sif.out_last, 1'b0);
    check16("rst_data", sif.out_data, 16'h0000);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // HB, full throughput, exact latency
    id = 16'h000C; hops = 16'h0003; qv = 16'h1234; en = 16'h8000;
    exp_words(6, 1, 16'h0006, 16'h000C, 16'h0004, 16'h1234, 16'h8000, 16'h6DB6);
    start(3'd0);
    check1("hb_busy_n1", busy, 1'b1);
    check1("hb_valid_n1", sif.out_valid, 1'b1);
    id = 16'hDEAD;
    wait_end(0, cyc, gd, ge);
    check16("hb_done_cycle", 16'(cyc), 16'd7);
    check1("hb_done", gd, 1'b1);
    check1("hb_done_busy", busy, 1'b0);
    check1("hb_done_valid", sif.out_valid, 1'b0);

    // JOIN accepted in the tx_done cycle (back-to-back)
    id = 16'h000C; chid = 16'h0005; qv = 16'h0100;
    exp_words(5, 1, 16'h4005, 16'h000C, 16'h0005, 16'h0100, 16'hBEEA, 16'h0000);
    start(3'd2);
    wait_end(0, cyc, gd, ge);
    check16("join_done_cycle", 16'(cyc), 16'd6);
    check1("join_done", gd, 1'b1);
    @(posedge clk);
    #1;
    check1("done_single_pulse", done, 1'b0);

    // HB with saturated hop count
    id = 16'h000C; hops = 16'hFFFF; qv = 16'h0001; en = 16'h0002;
    exp_words(6, 1, 16'h0006, 16'h000C, 16'hFFFF, 16'h0001, 16'h0002, 16'hFFEC);
    start(3'd0);
    wait_end(0, cyc, gd, ge);
    check1("hbsat_done", gd, 1'b1);
    @(posedge clk);
    #1;

    // CH_ANN under random backpressure, with a stray request mid-packet
    id = 16'h0007; chid = 16'h0003; emax = 16'hF000; emin = 16'h0100;
    exp_words(6, 1, 16'h2006, 16'h0007, 16'h0003, 16'hF000, 16'h0100, 16'hEEF0);
    bp_en = 1'b1;
    start(3'd1);
    wait_end(3, cyc, gd, ge);
    check1("chann_done", gd, 1'b1);
    check1("chann_no_err", ge, 1'b0);
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    check1("stray_req_ignored", busy, 1'b0);
    @(posedge clk);
    #1;

    // Invalid type
    tx_type = 3'b110;
    tx_req  = 1'b1;
    @(posedge clk);
    #1;
    tx_req = 1'b0;
    check1("inv_err", err, 1'b1);
    check1("inv_valid", sif.out_valid, 1'b0);
    check1("inv_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check1("inv_err_pulse", err, 1'b0);
    check1("inv_busy2", busy, 1'b0);

    // Stall abort after header (STALL_LIMIT = 4)
    id = 16'h000C; hops = 16'h0003; qv = 16'h1234; en = 16'h8000;
    exp_words(1, 0, 16'h0006, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    start(3'd0);
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check1("stall_still_valid", sif.out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    check1("stall_valid_drop", sif.out_valid, 1'b0);
    check1("stall_err", err, 1'b1);
    check1("stall_busy", busy, 1'b0);
    check1("stall_no_done", done, 1'b0);
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    check1("stall_err_pulse", err, 1'b0);
    check1("stall_no_done2", done, 1'b0);

    // DATA with reset during body word 3
    id = 16'h0009; chid = 16'h0005; hops = 16'h0002; din = 16'hABCD;
    exp_words(3, 0, 16'h6006, 16'h0009, 16'h0005, 16'h0, 16'h0, 16'h0);
    start(3'd3);
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    check1("mid_rst_valid", sif.out_valid, 1'b0);
    check1("mid_rst_last", sif.out_last, 1'b0);
    check16("mid_rst_data", sif.out_data, 16'h0000);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_done", done, 1'b0);
    check1("mid_rst_err", err, 1'b0);
    check16("mid_rst_flushed", 16'(exp_q.size()), 16'd0);

    // Complete DATA, then TSLOT
    exp_words(6, 1, 16'h6006, 16'h0009, 16'h0005, 16'h0002, 16'hABCD, 16'hF41D);
    start(3'd3);
    wait_end(0, cyc, gd, ge);
    check1("data_done", gd, 1'b1);
    mem = 16'h0011; ts = 16'h0003;
    exp_words(5, 1, 16'h8005, 16'h0009, 16'h0011, 16'h0003, 16'h7FDE, 16'h0000);
    start(3'd4);
    wait_end(0, cyc, gd, ge);
    check1("tslot_done", gd, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check16("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tx_pkt_builder.md
# tx_pkt_builder

Transmit-side packet assembler for the EER-RL node: on a request from the node controller it latches the node's own state (ID, hop count, Q-value, energy, cluster-head data), formats one outgoing packet of the requested type, and streams it out as 16-bit words over a valid/ready interface toward the radio/MAC. It builds the packet types that the node-info logic consumes on receive, appends a two's-complement checksum word, and aborts on a stalled link.

## Interface
- STALL_LIMIT, 255: consecutive stalled cycles (out_valid=1, out_ready=0) before abort; range 1..65535.
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- tx_req  in  1  request to send; sampled only in IDLE.
- tx_type  in  3  packet type: 000 HB, 001 CH_ANN, 010 JOIN, 011 DATA, 100 TSLOT; 101-111 invalid.
- my_node_id, hops_from_sink, my_q_value, energy, ch_id, e_max, e_min, member_id, timeslot, data_in  in  16 each  field sources, latched on accept.
- out_data  out  16  current word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts word when out_valid && out_ready.
- out_last  out  1  high with the checksum word.
- tx_busy  out  1  high in SEND/CSUM.
- tx_done  out  1  one-cycle pulse after checksum handshake.
- tx_err  out  1  one-cycle pulse on invalid type or stall abort.

## Operation
- States: IDLE, SEND, CSUM.
- IDLE: on tx_req with valid tx_type, latch type and all field inputs, clear word index, running sum and stall counter, go to SEND. Invalid tx_type: pulse tx_err next cycle, stay IDLE, no output.
- Header word = {type[2:0], 5'b0, word_count[7:0]}; word_count includes header and checksum.
- Word order after header (then checksum):
  - HB (6): my_node_id, hops_tx, my_q_value, energy.
  - CH_ANN (6): my_node_id, ch_id, e_max, e_min.
  - JOIN (5): my_node_id, ch_id, my_q_value.
  - DATA (6): my_node_id, ch_id, hops_from_sink, data_in.
  - TSLOT (5): my_node_id, member_id, timeslot.
- hops_tx = hops_from_sink + 1, saturating at 16'hFFFF (no wrap).
- Running sum: 16-bit, modulo 2^16, accumulates each word on its handshake.
- SEND: present word[index]; on handshake add to sum, increment index; after last body word handshake go to CSUM.
- CSUM: out_data = (0 - sum) mod 2^16, out_last=1; on handshake go IDLE, pulse tx_done. Sum of all words of a packet, including checksum, is 0 mod 2^16.
- Stall counter: increments each cycle with out_valid && !out_ready, clears on handshake. Reaching STALL_LIMIT: drop out_valid next cycle, pulse tx_err, return to IDLE, no tx_done.
- tx_req while busy is ignored (not queued). Field input changes after accept have no effect.

## Timing
- Reset: out_valid=0, out_last=0, out_data=0, tx_busy=0, tx_done=0, tx_err=0, state IDLE, counters 0. Reset mid-packet abandons it with no tx_done/tx_err.
- Accept at edge N (tx_req high in IDLE) -> header valid and tx_busy=1 from cycle N+1.
- Full-throughput sink: one word per cycle; 6-word packet occupies cycles N+1..N+6, tx_done high in N+7 with tx_busy=0 and out_valid=0.
- out_data/out_last held stable while out_valid && !out_ready.
- New tx_req earliest accepted in the tx_done cycle (back-to-back gap of one cycle).
- Invalid type at edge N -> tx_err high cycle N+1 only.
- Stall abort: counter reaches STALL_LIMIT after STALL_LIMIT stalled cycles; out_valid=0 and tx_err=1 in the following cycle.

## Test plan
- HB, my_node_id=0x000C, hops_from_sink=3, my_q_value=0x1234, energy=0x8000, out_ready=1 -> words 0x0006, 0x000C, 0x0004, 0x1234, 0x8000, 0x6DB6 (last on 0x6DB6), tx_done one cycle later.
- JOIN, id=0x000C, ch_id=0x0005, q=0x0100 -> 0x4005, 0x000C, 0x0005, 0x0100, 0xBEEA; then HB with hops_from_sink=0xFFFF -> hops word 0xFFFF.
- Random out_ready backpressure on CH_ANN -> same word sequence as unstalled run, words stable during stalls; tx_req pulses mid-packet ignored.
- tx_type=3'b110 -> tx_err single pulse, out_valid never asserts, tx_busy stays 0.
- STALL_LIMIT=4, out_ready=0 after header handshake -> 4 stalled cycles, then out_valid=0, tx_err pulse, IDLE, no tx_done.
- nrst low during body word 3 of DATA -> all outputs at reset values next cycle; subsequent request sends a complete correct packet.
